// File: rtl/prim_mubi_pkg.sv
// Multi-bit boolean encodings. A 4-bit mubi value is "true" or "false" only
// for its two legal codes; any other code is treated as invalid.
package prim_mubi_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

endpackage : prim_mubi_pkg

// File: rtl/rom_ctrl_pkg.sv
// Shared types for the ROM controller boot scan.
// scan_state_e uses a shortened (6,3) Hamming code so any two states differ
// in at least 3 bits; a single upset can never turn one legal state into
// another.
package rom_ctrl_pkg;

  localparam int unsigned TopCountDefault = 8;

  typedef enum logic [5:0] {
    ScanIdle     = 6'b001110,
    ScanReadData = 6'b010101,
    ScanReadTop  = 6'b100011,
    ScanWaitKmac = 6'b011011,
    ScanDone     = 6'b101101,
    ScanError    = 6'b110110
  } scan_state_e;

endpackage : rom_ctrl_pkg

// File: rtl/prim_flop.sv
// Plain register with synchronous active-high reset.
// Ports: clk_i, rst_i, d_i (next value), q_o (registered value).
module prim_flop #(
  parameter int unsigned       Width      = 1,
  parameter logic [Width-1:0]  ResetValue = {Width{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Storage with reset to ResetValue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= ResetValue;
    end else begin
      q_o <= d_i;
    end
  end

endmodule : prim_flop

// File: rtl/rom_ctrl_scan_buf.sv
// One-entry valid/ready holding stage between the ROM read port and KMAC.
// An arriving word is presented in the same cycle; if the consumer does not
// take it, it is held (data and last flag frozen) until accepted.
// Ports: in_valid_i/in_data_i/in_last_i (ROM response), out_valid_o/
// out_data_o/out_last_o/out_ready_i (KMAC side handshake).
module rom_ctrl_scan_buf #(
  parameter int unsigned DW = 39
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  input  logic          out_ready_i
);

  logic          full_q, full_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;

  // Output mux: a held word has priority; otherwise pass the arriving word.
  always_comb begin
    if (full_q) begin
      out_valid_o = 1'b1;
      out_data_o  = data_q;
      out_last_o  = last_q;
    end else if (in_valid_i) begin
      out_valid_o = 1'b1;
      out_data_o  = in_data_i;
      out_last_o  = in_last_i;
    end else begin
      out_valid_o = 1'b0;
      out_data_o  = {DW{1'b0}};
      out_last_o  = 1'b0;
    end
  end

  // Hold whatever is presented but not accepted.
  always_comb begin
    full_d = out_valid_o & ~out_ready_i;
    data_d = full_d ? out_data_o : data_q;
    last_d = full_d ? out_last_o : last_q;
  end

  // Holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= {DW{1'b0}};
    end else begin
      full_q <= full_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

endmodule : rom_ctrl_scan_buf

// File: rtl/rom_ctrl_scan_seq.sv
// Boot-time ROM scan sequencer. After start_i it reads every ROM word in
// order, streams the data words to KMAC, writes the top TopCount words into
// the expected-digest register, waits for the digest result and then hands
// the ROM to the bus (sel_bus_o = MuBi4True, never reverted).
// Ports: chk_req_o/chk_addr_o/chk_rdata_i/rom_rvalid_i (ROM mux checker
// side), kmac_* (digest stream), exp_digest_* (expected-digest writes),
// sel_bus_o/done_o/good_o/alert_o (status).
module rom_ctrl_scan_seq
  import rom_ctrl_pkg::*;
  import prim_mubi_pkg::*;
#(
  parameter  int unsigned AW       = 8,
  parameter  int unsigned DW       = 39,
  parameter  int unsigned RomDepth = 2**AW,
  parameter  int unsigned TopCount = TopCountDefault,
  localparam int unsigned IdxW     = $clog2(TopCount)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            chk_req_o,
  output logic [AW-1:0]   chk_addr_o,
  input  logic [DW-1:0]   chk_rdata_i,
  input  logic            rom_rvalid_i,
  output logic [DW-1:0]   kmac_data_o,
  output logic            kmac_valid_o,
  input  logic            kmac_ready_i,
  output logic            kmac_last_o,
  input  logic            kmac_done_i,
  input  logic            digest_match_i,
  output logic            exp_digest_we_o,
  output logic [IdxW-1:0] exp_digest_idx_o,
  output logic [31:0]     exp_digest_o,
  output mubi4_t          sel_bus_o,
  output logic            done_o,
  output logic            good_o,
  output logic            alert_o
);

  localparam logic [AW-1:0] TopBase  = AW'(RomDepth - TopCount);
  localparam logic [AW-1:0] LastData = AW'(RomDepth - TopCount - 1);
  localparam logic [AW-1:0] LastAddr = AW'(RomDepth - 1);
  localparam logic [AW-1:0] AddrOne  = AW'(1);

  logic [5:0]    state_raw;
  scan_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;        // next address to request
  logic [AW-1:0] rd_addr_q, rd_addr_d;  // address of the read in flight
  logic          pend_q, pend_d;
  logic          good_q, good_d, done_q, done_d, alert_q, alert_d;
  mubi4_t        sel_q, sel_d;

  logic          req_s, rsp_s, err_s, top_last_rsp_s, buf_in_valid_s;
  logic          buf_valid_s, buf_last_s;
  logic [DW-1:0] buf_data_s;
  logic [IdxW-1:0] exp_idx_s;

  assign rsp_s          = rom_rvalid_i & pend_q;
  // A response with nothing in flight, or a digest result we did not ask for.
  assign err_s          = (rom_rvalid_i & ~pend_q) |
                          (kmac_done_i & (state_q != ScanWaitKmac));
  assign top_last_rsp_s = rsp_s & (rd_addr_q == LastAddr);
  assign buf_in_valid_s = rsp_s & (state_q == ScanReadData);
  assign exp_idx_s      = IdxW'(rd_addr_q - TopBase);

  // Request generation. In ReadData a response arriving this cycle frees the
  // in-flight slot, giving one word per cycle while KMAC keeps up. ReadTop
  // stops once the last address is in flight, so the counter never wraps.
  always_comb begin
    req_s = 1'b0;
    case (state_q)
      ScanReadData: req_s = (addr_q <= LastData) && (!pend_q || rom_rvalid_i) &&
                            (!buf_valid_s || kmac_ready_i);
      ScanReadTop:  req_s = !(pend_q && (rd_addr_q == LastAddr));
      default:      req_s = 1'b0;
    endcase
  end

  // Address counter and in-flight tracking.
  always_comb begin
    rd_addr_d = rd_addr_q;
    pend_d    = pend_q & ~rom_rvalid_i;
    addr_d    = addr_q;
    if (req_s) begin
      rd_addr_d = addr_q;
      pend_d    = 1'b1;
      addr_d    = (addr_q == LastAddr) ? addr_q : addr_q + AddrOne;
    end else if (state_q == ScanIdle) begin
      addr_d    = {AW{1'b0}};
    end else begin
      addr_d    = addr_q;
    end
  end

  // Next-state logic; any unrecognised encoding decodes to Error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ScanIdle:     state_d = err_s ? ScanError : (start_i ? ScanReadData : ScanIdle);
      ScanReadData: state_d = err_s ? ScanError :
                              ((buf_valid_s && buf_last_s && kmac_ready_i) ? ScanReadTop
                                                                          : ScanReadData);
      ScanReadTop:  state_d = err_s ? ScanError : (top_last_rsp_s ? ScanWaitKmac : ScanReadTop);
      ScanWaitKmac: state_d = err_s ? ScanError : (kmac_done_i ? ScanDone : ScanWaitKmac);
      ScanDone:     state_d = ScanDone;
      ScanError:    state_d = ScanError;
      default:      state_d = ScanError;
    endcase
  end

  // Status outputs. Once the bus owns the ROM it keeps it until reset.
  always_comb begin
    if ((state_q == ScanWaitKmac) && (state_d == ScanDone)) begin
      good_d = digest_match_i;
    end else begin
      good_d = good_q;
    end
    done_d  = (state_d == ScanDone);
    alert_d = alert_q | (state_d == ScanError);
    sel_d   = ((sel_q == MuBi4True) || (state_d == ScanDone)) ? MuBi4True : MuBi4False;
  end

  prim_flop #(
    .Width      (6),
    .ResetValue (6'(ScanIdle))
  ) u_state_regs (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (state_d),
    .q_o   (state_raw)
  );
  assign state_q = scan_state_e'(state_raw);

  // Datapath and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= {AW{1'b0}};
      rd_addr_q <= {AW{1'b0}};
      pend_q    <= 1'b0;
      good_q    <= 1'b0;
      done_q    <= 1'b0;
      alert_q   <= 1'b0;
      sel_q     <= MuBi4False;
    end else begin
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      pend_q    <= pend_d;
      good_q    <= good_d;
      done_q    <= done_d;
      alert_q   <= alert_d;
      sel_q     <= sel_d;
    end
  end

  rom_ctrl_scan_buf #(
    .DW (DW)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (buf_in_valid_s),
    .in_data_i   (chk_rdata_i),
    .in_last_i   (rd_addr_q == LastData),
    .out_valid_o (buf_valid_s),
    .out_data_o  (buf_data_s),
    .out_last_o  (buf_last_s),
    .out_ready_i (kmac_ready_i)
  );

  assign chk_req_o        = req_s;
  assign chk_addr_o       = addr_q;
  assign kmac_valid_o     = buf_valid_s;
  assign kmac_data_o      = buf_data_s;
  assign kmac_last_o      = buf_last_s;
  assign exp_digest_we_o  = rsp_s & (state_q == ScanReadTop);
  assign exp_digest_idx_o = exp_digest_we_o ? exp_idx_s : {IdxW{1'b0}};
  assign exp_digest_o     = exp_digest_we_o ? chk_rdata_i[31:0] : 32'h0000_0000;
  assign sel_bus_o        = sel_q;
  assign done_o           = done_q;
  assign good_o           = good_q;
  assign alert_o          = alert_q;

endmodule : rom_ctrl_scan_seq

// File: tb/tb_rom_ctrl_scan_seq.sv
// Scoreboard bench for rom_ctrl_scan_seq: expected KMAC words and digest
// writes are queued when a scan is started; a monitor pops them as the DUT
// presents them. Directed sections cover reset, backpressure, mismatch,
// spurious responses and reset mid-scan.
module tb_rom_ctrl_scan_seq;

  localparam int AW    = 8;
  localparam int DW    = 39;
  localparam int DEPTH = 256;
  localparam int TOP   = 8;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          rst_i, start_i, kmac_ready_i, kmac_done_i, digest_match_i;
  logic          chk_req_o, kmac_valid_o, kmac_last_o, exp_digest_we_o;
  logic [AW-1:0] chk_addr_o;
  logic [DW-1:0] chk_rdata_i, kmac_data_o;
  logic          rom_rvalid_i, rom_rvalid_q, spur_rvalid;
  logic [IW-1:0] exp_digest_idx_o;
  logic [31:0]   exp_digest_o;
  logic [3:0]    sel_bus_o;
  logic          done_o, good_o, alert_o;

  typedef struct packed { logic [DW-1:0] data; logic last; } kexp_t;
  typedef struct packed { logic [IW-1:0] idx; logic [31:0] data; } dexp_t;
  kexp_t kq[$];
  dexp_t dq[$];
  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rom_ctrl_scan_seq dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .chk_req_o        (chk_req_o),
    .chk_addr_o       (chk_addr_o),
    .chk_rdata_i      (chk_rdata_i),
    .rom_rvalid_i     (rom_rvalid_i),
    .kmac_data_o      (kmac_data_o),
    .kmac_valid_o     (kmac_valid_o),
    .kmac_ready_i     (kmac_ready_i),
    .kmac_last_o      (kmac_last_o),
    .kmac_done_i      (kmac_done_i),
    .digest_match_i   (digest_match_i),
    .exp_digest_we_o  (exp_digest_we_o),
    .exp_digest_idx_o (exp_digest_idx_o),
    .exp_digest_o     (exp_digest_o),
    .sel_bus_o        (sel_bus_o),
    .done_o           (done_o),
    .good_o           (good_o),
    .alert_o          (alert_o)
  );

  function automatic logic [DW-1:0] rom_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {7'h55, b, 24'hC0FFEE ^ {b, b, b}};
  endfunction

  // ROM model: answers every request one cycle later.
  always @(posedge clk) begin
    if (rst_i) begin
      rom_rvalid_q <= 1'b0;
      chk_rdata_i  <= '0;
    end else begin
      rom_rvalid_q <= chk_req_o;
      chk_rdata_i  <= rom_word(int'(chk_addr_o));
    end
  end
  assign rom_rvalid_i = rom_rvalid_q | spur_rvalid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_scan();
    logic [DW-1:0] w;
    for (int a = 0; a < DEPTH - TOP; a++)
      kq.push_back('{data: rom_word(a), last: (a == DEPTH - TOP - 1)});
    for (int i = 0; i < TOP; i++) begin
      w = rom_word(DEPTH - TOP + i);
      dq.push_back('{idx: IW'(i), data: w[31:0]});
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((kq.size() != 0 || dq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(kq.size() + dq.size()), 64'd0);
  endtask

  task automatic finish_scan(input logic match, input string name);
    check({name, "_done_before"}, 64'(done_o), 64'd0);
    check({name, "_sel_before"}, 64'(sel_bus_o), 64'h9);
    kmac_done_i    = 1'b1;
    digest_match_i = match;
    @(negedge clk);
    kmac_done_i    = 1'b0;
    digest_match_i = 1'b0;
    check({name, "_done"}, 64'(done_o), 64'd1);
    check({name, "_good"}, 64'(good_o), 64'(match));
    check({name, "_sel"}, 64'(sel_bus_o), 64'h6);
    check({name, "_alert"}, 64'(alert_o), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_sel_held"}, 64'(sel_bus_o), 64'h6);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word or write.
  initial begin
    kexp_t ke;
    dexp_t de;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i) begin
        if (kmac_valid_o && kmac_ready_i) begin
          if (kq.size() == 0) begin
            total++;
            $display("FAIL kmac_unexpected: word 0x%0h with nothing expected", kmac_data_o);
          end else begin
            ke = kq.pop_front();
            check("kmac_data", 64'(kmac_data_o), 64'(ke.data));
            check("kmac_last", 64'(kmac_last_o), 64'(ke.last));
          end
        end
        if (exp_digest_we_o) begin
          if (dq.size() == 0) begin
            total++;
            $display("FAIL digest_unexpected: idx %0d with nothing expected", exp_digest_idx_o);
          end else begin
            de = dq.pop_front();
            check("digest_idx", 64'(exp_digest_idx_o), 64'(de.idx));
            check("digest_data", 64'(exp_digest_o), 64'(de.data));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0; kmac_ready_i = 1'b1;
    kmac_done_i = 1'b0; digest_match_i = 1'b0; spur_rvalid = 1'b0;

    // Reset values.
    reset_dut();
    check("rst_sel", 64'(sel_bus_o), 64'h9);
    check("rst_req", 64'(chk_req_o), 64'd0);
    check("rst_kvalid", 64'(kmac_valid_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_alert", 64'(alert_o), 64'd0);

    // Full scan with a 5-cycle stall on word 10, digest match.
    push_scan();
    pulse_start();
    n = 0;
    while (!(kmac_valid_o && kmac_data_o == rom_word(10)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_word10_seen", 64'(kmac_data_o), 64'(rom_word(10)));
    kmac_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("bp_valid", 64'(kmac_valid_o), 64'd1);
      check("bp_data", 64'(kmac_data_o), 64'(rom_word(10)));
      check("bp_no_req", 64'(chk_req_o), 64'd0);
    end
    @(negedge clk);
    kmac_ready_i = 1'b1;
    #1;
    check("bp_req11", 64'(chk_req_o), 64'd1);
    check("bp_addr11", 64'(chk_addr_o), 64'd11);
    wait_drained("scan1_drain");
    finish_scan(1'b1, "scan1");

    // Reset while address 100 is requested, then restart from 0; mismatch.
    reset_dut();
    push_scan();
    pulse_start();
    n = 0;
    while (!(chk_req_o && chk_addr_o == 8'd100) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_addr100_seen", 64'(chk_addr_o), 64'd100);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_idle_req", 64'(chk_req_o), 64'd0);
    check("mid_idle_kvalid", 64'(kmac_valid_o), 64'd0);
    check("mid_idle_sel", 64'(sel_bus_o), 64'h9);
    check("mid_idle_alert", 64'(alert_o), 64'd0);
    kq.delete();
    dq.delete();
    push_scan();
    pulse_start();
    check("restart_kvalid", 64'(kmac_valid_o), 64'd0);
    check("restart_addr0", 64'(chk_addr_o), 64'd0);
    wait_drained("scan2_drain");
    finish_scan(1'b0, "scan2");

    // Spurious ROM response in Idle: alert, bus stays with the checker.
    reset_dut();
    repeat (2) @(negedge clk);
    spur_rvalid = 1'b1;
    @(negedge clk);
    spur_rvalid = 1'b0;
    check("spur_alert", 64'(alert_o), 64'd1);
    check("spur_sel", 64'(sel_bus_o), 64'h9);
    pulse_start();
    repeat (3) @(negedge clk);
    check("spur_alert_sticky", 64'(alert_o), 64'd1);
    check("spur_sel_held", 64'(sel_bus_o), 64'h9);
    check("spur_start_ignored", 64'(chk_req_o), 64'd0);

    // Digest result outside WaitKmac is also fatal.
    reset_dut();
    check("kdone_pre_alert", 64'(alert_o), 64'd0);
    kmac_done_i = 1'b1;
    @(negedge clk);
    kmac_done_i = 1'b0;
    check("kdone_idle_alert", 64'(alert_o), 64'd1);
    check("kdone_idle_done", 64'(done_o), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_rom_ctrl_scan_seq
